// File: rtl/maxi_req_arbiter_if.sv
// Request/completion bundle for one side of the arbiter.
// The master modport issues requests and consumes completions; slave is the opposite side.
interface maxi_req_arbiter_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [2:0]  mem_req_bar_hit;
  logic [31:0] mem_req_pcie_address;
  logic [7:0]  mem_req_byte_enable;
  logic        mem_req_write_readn;
  logic        mem_req_phys_func;
  logic [63:0] mem_req_write_data;
  logic        cpld_valid;
  logic        cpld_ready;
  logic [63:0] cpld_data;

  modport master (
    output mem_req_valid, mem_req_bar_hit, mem_req_pcie_address, mem_req_byte_enable,
           mem_req_write_readn, mem_req_phys_func, mem_req_write_data, cpld_ready,
    input  mem_req_ready, cpld_valid, cpld_data
  );

  modport slave (
    input  mem_req_valid, mem_req_bar_hit, mem_req_pcie_address, mem_req_byte_enable,
           mem_req_write_readn, mem_req_phys_func, mem_req_write_data, cpld_ready,
    output mem_req_ready, cpld_valid, cpld_data
  );
endinterface

// File: rtl/maxi_req_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite request path between two requesters,
// with an in-order route FIFO that steers read completions back to their owner.
module maxi_req_arbiter #(
  parameter int OUTSTANDING_READS = 5
) (
  input  logic              m_axi_aclk,
  input  logic              m_axi_aresetn,
  maxi_req_arbiter_if.slave  s0,
  maxi_req_arbiter_if.slave  s1,
  maxi_req_arbiter_if.master m,
  output logic              orphan_cpld
);

  localparam int PW = (OUTSTANDING_READS > 1) ? $clog2(OUTSTANDING_READS) : 1;
  localparam int CW = $clog2(OUTSTANDING_READS + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state, state_nxt;
  logic            rr_ptr;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   rd_count;
  logic            route_mem [OUTSTANDING_READS];

  logic            el0, el1;
  logic            accept, win, win_write, push, pop;
  logic            fifo_empty, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING_READS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads are held back once every route FIFO slot is in use; writes never are.
  assign el0 = s0.mem_req_valid && (s0.mem_req_write_readn || (rd_count < CW'(OUTSTANDING_READS)));
  assign el1 = s1.mem_req_valid && (s1.mem_req_write_readn || (rd_count < CW'(OUTSTANDING_READS)));

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) state <= IDLE;
    else                state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    win       = 1'b0;
    case (state)
      IDLE: begin
        // Gate with reset so a waiting requester sees no ready pulse during reset.
        if (m_axi_aresetn && (el0 || el1)) begin
          accept    = 1'b1;
          win       = (el0 && el1) ? rr_ptr : el1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   if (m.mem_req_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign s0.mem_req_ready = accept && !win;
  assign s1.mem_req_ready = accept &&  win;
  assign m.mem_req_valid  = (state == ISSUE);

  assign win_write = win ? s1.mem_req_write_readn : s0.mem_req_write_readn;
  assign push      = accept && !win_write;

  // NOTE: output fields use non-blocking assignments and reset to zero; they only load on accept,
  // so they stay stable while ISSUE waits on back-pressure.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      rr_ptr                 <= 1'b0;
      m.mem_req_bar_hit      <= '0;
      m.mem_req_pcie_address <= '0;
      m.mem_req_byte_enable  <= '0;
      m.mem_req_write_readn  <= 1'b0;
      m.mem_req_phys_func    <= 1'b0;
      m.mem_req_write_data   <= '0;
    end else if (accept) begin
      rr_ptr                 <= ~win;
      m.mem_req_bar_hit      <= win ? s1.mem_req_bar_hit      : s0.mem_req_bar_hit;
      m.mem_req_pcie_address <= win ? s1.mem_req_pcie_address : s0.mem_req_pcie_address;
      m.mem_req_byte_enable  <= win ? s1.mem_req_byte_enable  : s0.mem_req_byte_enable;
      m.mem_req_write_readn  <= win_write;
      m.mem_req_phys_func    <= win ? s1.mem_req_phys_func    : s0.mem_req_phys_func;
      m.mem_req_write_data   <= win ? s1.mem_req_write_data   : s0.mem_req_write_data;
    end
  end

  // NOTE: route storage has no reset; pointers and rd_count define which entries are live.
  always_ff @(posedge m_axi_aclk) begin
    if (push) route_mem[wr_ptr] <= win;
  end

  assign fifo_empty = (rd_count == '0);
  assign head       = route_mem[rd_ptr];

  assign s0.cpld_valid = !fifo_empty && !head && m.cpld_valid;
  assign s1.cpld_valid = !fifo_empty &&  head && m.cpld_valid;
  assign m.cpld_ready  = !fifo_empty && (head ? s1.cpld_ready : s0.cpld_ready);
  assign s0.cpld_data  = m.cpld_data;
  assign s1.cpld_data  = m.cpld_data;
  assign pop           = m.cpld_valid && m.cpld_ready;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_count    <= '0;
      orphan_cpld <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   rd_count <= rd_count + CW'(1);
        2'b01:   rd_count <= rd_count - CW'(1);
        default: rd_count <= rd_count;
      endcase
      if (fifo_empty && m.cpld_valid) orphan_cpld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_maxi_req_arbiter.sv
// Directed bench for maxi_req_arbiter: arbitration, routing, full FIFO, back-pressure, reset, orphan.
module tb_maxi_req_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic orphan;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  maxi_req_arbiter_if s0_if ();
  maxi_req_arbiter_if s1_if ();
  maxi_req_arbiter_if m_if ();

  maxi_req_arbiter #(.OUTSTANDING_READS(5)) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .s0            (s0_if),
    .s1            (s1_if),
    .m             (m_if),
    .orphan_cpld   (orphan)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic wr,
                         input logic [31:0] addr, input logic [63:0] data);
    if (n == 0) begin
      s0_if.mem_req_valid = v;        s0_if.mem_req_write_readn = wr;
      s0_if.mem_req_pcie_address = addr; s0_if.mem_req_write_data = data;
      s0_if.mem_req_byte_enable = 8'hFF; s0_if.mem_req_bar_hit = 3'd2;
      s0_if.mem_req_phys_func = 1'b0;
    end else begin
      s1_if.mem_req_valid = v;        s1_if.mem_req_write_readn = wr;
      s1_if.mem_req_pcie_address = addr; s1_if.mem_req_write_data = data;
      s1_if.mem_req_byte_enable = 8'h0F; s1_if.mem_req_bar_hit = 3'd1;
      s1_if.mem_req_phys_func = 1'b1;
    end
  endtask

  // Holds a request until accepted (bounded), then drops it in the following ISSUE cycle.
  task automatic issue(input int n, input logic wr, input logic [31:0] addr,
                       input logic [63:0] data, input string name);
    bit done = 1'b0;
    set_req(n, 1'b1, wr, addr, data);
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if ((n == 0) ? s0_if.mem_req_ready : s1_if.mem_req_ready) done = 1'b1;
      tick();
    end
    set_req(n, 1'b0, wr, addr, data);
    checks++;
    if (!done) begin errors++; $display("FAIL %s accept timeout got=0 exp=1", name); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s0_if.mem_req_valid = 1'b1;
    #1;
    checks++; if (m_if.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%0b exp=0", m_if.mem_req_valid); end
    checks++; if (s0_if.mem_req_ready !== 1'b0) begin errors++; $display("FAIL rst_s0_ready got=%0b exp=0", s0_if.mem_req_ready); end
    checks++; if (m_if.mem_req_pcie_address !== 32'h0) begin errors++; $display("FAIL rst_addr got=%0h exp=0", m_if.mem_req_pcie_address); end
    checks++; if (m_if.cpld_ready !== 1'b0) begin errors++; $display("FAIL rst_cpld_ready got=%0b exp=0", m_if.cpld_ready); end
    checks++; if (orphan !== 1'b0) begin errors++; $display("FAIL rst_orphan got=%0b exp=0", orphan); end
    s0_if.mem_req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    m_if.mem_req_ready = 1'b1;
    set_req(0, 1'b1, 1'b1, 32'h10, 64'h1);
    set_req(1, 1'b1, 1'b1, 32'h20, 64'h2);
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k % 2 == 0) begin
        checks++; if (s0_if.mem_req_ready !== (k % 4 == 0)) begin errors++; $display("FAIL rr_s0_ready k=%0d got=%0b exp=%0b", k, s0_if.mem_req_ready, k % 4 == 0); end
        checks++; if (s1_if.mem_req_ready !== (k % 4 == 2)) begin errors++; $display("FAIL rr_s1_ready k=%0d got=%0b exp=%0b", k, s1_if.mem_req_ready, k % 4 == 2); end
      end else begin
        checks++; if (m_if.mem_req_valid !== 1'b1) begin errors++; $display("FAIL rr_m_valid k=%0d got=%0b exp=1", k, m_if.mem_req_valid); end
        checks++; if (m_if.mem_req_pcie_address !== ((k % 4 == 1) ? 32'h10 : 32'h20)) begin
          errors++; $display("FAIL rr_addr k=%0d got=%0h exp=%0h", k, m_if.mem_req_pcie_address, (k % 4 == 1) ? 32'h10 : 32'h20); end
        checks++; if ((s0_if.mem_req_ready | s1_if.mem_req_ready) !== 1'b0) begin errors++; $display("FAIL rr_ready_in_issue k=%0d got=1 exp=0", k); end
      end
      tick();
    end
    set_req(0, 1'b0, 1'b1, 32'h0, 64'h0);
    set_req(1, 1'b0, 1'b1, 32'h0, 64'h0);
    tick();
  endtask

  task automatic test_single_write();
    set_req(0, 1'b1, 1'b1, 32'h100, 64'hDEAD_BEEF);
    #1;
    checks++; if (s0_if.mem_req_ready !== 1'b1) begin errors++; $display("FAIL sw_s0_ready got=%0b exp=1", s0_if.mem_req_ready); end
    checks++; if (m_if.mem_req_valid !== 1'b0) begin errors++; $display("FAIL sw_m_valid_T got=%0b exp=0", m_if.mem_req_valid); end
    tick();
    set_req(0, 1'b0, 1'b1, 32'h0, 64'h0);
    #1;
    checks++; if (m_if.mem_req_valid !== 1'b1) begin errors++; $display("FAIL sw_m_valid_T1 got=%0b exp=1", m_if.mem_req_valid); end
    checks++; if (m_if.mem_req_pcie_address !== 32'h100) begin errors++; $display("FAIL sw_addr got=%0h exp=100", m_if.mem_req_pcie_address); end
    checks++; if (m_if.mem_req_write_data !== 64'hDEAD_BEEF) begin errors++; $display("FAIL sw_data got=%0h exp=deadbeef", m_if.mem_req_write_data); end
    checks++; if (m_if.mem_req_write_readn !== 1'b1) begin errors++; $display("FAIL sw_wr got=%0b exp=1", m_if.mem_req_write_readn); end
    checks++; if (m_if.mem_req_byte_enable !== 8'hFF) begin errors++; $display("FAIL sw_be got=%0h exp=ff", m_if.mem_req_byte_enable); end
    checks++; if (m_if.mem_req_bar_hit !== 3'd2) begin errors++; $display("FAIL sw_bar got=%0d exp=2", m_if.mem_req_bar_hit); end
    checks++; if (m_if.mem_req_phys_func !== 1'b0) begin errors++; $display("FAIL sw_pf got=%0b exp=0", m_if.mem_req_phys_func); end
    checks++; if (dut.rd_count !== 3'd0) begin errors++; $display("FAIL sw_rd_count got=%0d exp=0", dut.rd_count); end
    tick();
    checks++; if (m_if.mem_req_valid !== 1'b0) begin errors++; $display("FAIL sw_m_valid_T2 got=%0b exp=0", m_if.mem_req_valid); end
  endtask

  task automatic test_read_routing();
    logic [63:0] dat [3];
    int          dst [3];
    dat[0] = 64'hA; dat[1] = 64'hB; dat[2] = 64'hC;
    dst[0] = 1;     dst[1] = 0;     dst[2] = 1;
    issue(1, 1'b0, 32'h200, 64'h0, "rt_rd0");
    issue(0, 1'b0, 32'h204, 64'h0, "rt_rd1");
    issue(1, 1'b0, 32'h208, 64'h0, "rt_rd2");
    checks++; if (dut.rd_count !== 3'd3) begin errors++; $display("FAIL rt_count3 got=%0d exp=3", dut.rd_count); end
    s0_if.cpld_ready = 1'b1;
    s1_if.cpld_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_if.cpld_valid = 1'b1;
      m_if.cpld_data  = dat[i];
      #1;
      checks++; if (s0_if.cpld_valid !== (dst[i] == 0)) begin errors++; $display("FAIL rt_s0_valid i=%0d got=%0b exp=%0b", i, s0_if.cpld_valid, dst[i] == 0); end
      checks++; if (s1_if.cpld_valid !== (dst[i] == 1)) begin errors++; $display("FAIL rt_s1_valid i=%0d got=%0b exp=%0b", i, s1_if.cpld_valid, dst[i] == 1); end
      checks++; if (((dst[i] == 1) ? s1_if.cpld_data : s0_if.cpld_data) !== dat[i]) begin errors++; $display("FAIL rt_data i=%0d exp=%0h", i, dat[i]); end
      checks++; if (m_if.cpld_ready !== 1'b1) begin errors++; $display("FAIL rt_cpld_ready i=%0d got=%0b exp=1", i, m_if.cpld_ready); end
      tick();
      checks++; if (dut.rd_count !== 3'(2 - i)) begin errors++; $display("FAIL rt_count i=%0d got=%0d exp=%0d", i, dut.rd_count, 2 - i); end
    end
    m_if.cpld_valid = 1'b0;
    s0_if.cpld_ready = 1'b0;
    s1_if.cpld_ready = 1'b0;
    tick();
  endtask

  task automatic test_full_fifo();
    for (int i = 0; i < 5; i++) issue(0, 1'b0, 32'h400 + 32'(i * 4), 64'h0, "ff_rd");
    checks++; if (dut.rd_count !== 3'd5) begin errors++; $display("FAIL ff_count5 got=%0d exp=5", dut.rd_count); end
    set_req(0, 1'b1, 1'b0, 32'h500, 64'h0);
    set_req(1, 1'b1, 1'b1, 32'h600, 64'h66);
    tick();
    #1;
    checks++; if (s0_if.mem_req_ready !== 1'b0) begin errors++; $display("FAIL ff_rd6_blocked got=%0b exp=0", s0_if.mem_req_ready); end
    checks++; if (s1_if.mem_req_ready !== 1'b1) begin errors++; $display("FAIL ff_wr_bypass got=%0b exp=1", s1_if.mem_req_ready); end
    tick();
    set_req(1, 1'b0, 1'b1, 32'h600, 64'h66);
    #1;
    checks++; if (m_if.mem_req_pcie_address !== 32'h600) begin errors++; $display("FAIL ff_wr_addr got=%0h exp=600", m_if.mem_req_pcie_address); end
    tick();
    m_if.cpld_valid  = 1'b1;
    m_if.cpld_data   = 64'h55;
    s0_if.cpld_ready = 1'b1;
    #1;
    checks++; if (s0_if.mem_req_ready !== 1'b0) begin errors++; $display("FAIL ff_rd6_still_blocked got=%0b exp=0", s0_if.mem_req_ready); end
    checks++; if (s0_if.cpld_valid !== 1'b1) begin errors++; $display("FAIL ff_cpld_s0 got=%0b exp=1", s0_if.cpld_valid); end
    tick();
    m_if.cpld_valid = 1'b0;
    #1;
    checks++; if (dut.rd_count !== 3'd4) begin errors++; $display("FAIL ff_count4 got=%0d exp=4", dut.rd_count); end
    checks++; if (s0_if.mem_req_ready !== 1'b1) begin errors++; $display("FAIL ff_rd6_accept got=%0b exp=1", s0_if.mem_req_ready); end
    tick();
    set_req(0, 1'b0, 1'b0, 32'h0, 64'h0);
    checks++; if (dut.rd_count !== 3'd5) begin errors++; $display("FAIL ff_count5b got=%0d exp=5", dut.rd_count); end
    m_if.cpld_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    m_if.cpld_valid = 1'b0;
    s0_if.cpld_ready = 1'b0;
    checks++; if (dut.rd_count !== 3'd0) begin errors++; $display("FAIL ff_drain got=%0d exp=0", dut.rd_count); end
    tick();
  endtask

  task automatic test_backpressure_reset();
    issue(1, 1'b0, 32'h700, 64'h0, "bp_rd");
    s1_if.cpld_ready = 1'b0;
    m_if.cpld_valid  = 1'b1;
    m_if.cpld_data   = 64'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (m_if.cpld_ready !== 1'b0) begin errors++; $display("FAIL bp_cpld_ready i=%0d got=%0b exp=0", i, m_if.cpld_ready); end
      checks++; if (s1_if.cpld_valid !== 1'b1) begin errors++; $display("FAIL bp_s1_valid i=%0d got=%0b exp=1", i, s1_if.cpld_valid); end
      tick();
    end
    m_if.cpld_valid = 1'b0;
    checks++; if (dut.rd_count !== 3'd1) begin errors++; $display("FAIL bp_no_pop got=%0d exp=1", dut.rd_count); end
    tick();
    m_if.mem_req_ready = 1'b0;
    issue(0, 1'b1, 32'h300, 64'h1234, "bp_wr");
    tick();
    checks++; if (m_if.mem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got=%0b exp=1", m_if.mem_req_valid); end
    checks++; if (m_if.mem_req_pcie_address !== 32'h300) begin errors++; $display("FAIL bp_hold_addr got=%0h exp=300", m_if.mem_req_pcie_address); end
    rst_n = 1'b0;
    s0_if.mem_req_valid = 1'b1;
    #1;
    checks++; if (m_if.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rs_m_valid got=%0b exp=0", m_if.mem_req_valid); end
    checks++; if (m_if.mem_req_write_data !== 64'h0) begin errors++; $display("FAIL rs_data got=%0h exp=0", m_if.mem_req_write_data); end
    checks++; if (m_if.mem_req_pcie_address !== 32'h0) begin errors++; $display("FAIL rs_addr got=%0h exp=0", m_if.mem_req_pcie_address); end
    checks++; if (s0_if.mem_req_ready !== 1'b0) begin errors++; $display("FAIL rs_s0_ready got=%0b exp=0", s0_if.mem_req_ready); end
    checks++; if (dut.rd_count !== 3'd0) begin errors++; $display("FAIL rs_count got=%0d exp=0", dut.rd_count); end
    s0_if.mem_req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    m_if.mem_req_ready = 1'b1;
    tick();
  endtask

  task automatic test_orphan();
    s0_if.cpld_ready = 1'b1;
    s1_if.cpld_ready = 1'b1;
    checks++; if (orphan !== 1'b0) begin errors++; $display("FAIL or_before got=%0b exp=0", orphan); end
    m_if.cpld_valid = 1'b1;
    m_if.cpld_data  = 64'h99;
    #1;
    checks++; if ((s0_if.cpld_valid | s1_if.cpld_valid) !== 1'b0) begin errors++; $display("FAIL or_cpld_valid got=1 exp=0"); end
    checks++; if (m_if.cpld_ready !== 1'b0) begin errors++; $display("FAIL or_cpld_ready got=%0b exp=0", m_if.cpld_ready); end
    tick();
    m_if.cpld_valid = 1'b0;
    checks++; if (orphan !== 1'b1) begin errors++; $display("FAIL or_set got=%0b exp=1", orphan); end
    tick();
    tick();
    checks++; if (orphan !== 1'b1) begin errors++; $display("FAIL or_sticky got=%0b exp=1", orphan); end
  endtask

  initial begin
    set_req(0, 1'b0, 1'b0, 32'h0, 64'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 64'h0);
    s0_if.cpld_ready   = 1'b0;
    s1_if.cpld_ready   = 1'b0;
    m_if.mem_req_ready = 1'b1;
    m_if.cpld_valid    = 1'b0;
    m_if.cpld_data     = 64'h0;
    test_reset();
    test_round_robin();
    test_single_write();
    test_read_routing();
    test_full_fifo();
    test_backpressure_reset();
    test_orphan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
